// File: rtl/hex_monitor_pkg.sv
// Shared constants for the hex monitor: character cell geometry, pixel colours for
// 8- and 16-bit displays, page FSM state encoding and the built-in 6x8 hex glyph set.
// No ports.
package hex_monitor_pkg;

  localparam int unsigned CellW = 6;
  localparam int unsigned CellH = 8;

  localparam logic [15:0] ColWhite16 = 16'hFFFF;
  localparam logic [15:0] ColRed16   = 16'hF800;
  localparam logic [7:0]  ColWhite8  = 8'hFF;
  localparam logic [7:0]  ColRed8    = 8'hE0;

  typedef logic [0:0] pg_state_t;
  localparam pg_state_t PG_IDLE    = 1'b0;
  localparam pg_state_t PG_PENDING = 1'b1;

  // One glyph per entry, line 0 in the top byte; each byte holds 5 pixels,
  // bit 4 = leftmost pixel. Line 7 is the blank inter-row gap.
  localparam logic [63:0] FontTable [16] = '{
    64'h0E11_1315_1911_0E00, 64'h040C_0404_0404_0E00,
    64'h0E11_0102_0408_1F00, 64'h1F02_0402_0111_0E00,
    64'h0206_0A12_1F02_0200, 64'h1F10_1E01_0111_0E00,
    64'h0608_101E_1111_0E00, 64'h1F01_0204_0808_0800,
    64'h0E11_110E_1111_0E00, 64'h0E11_110F_0102_0C00,
    64'h0E11_111F_1111_1100, 64'h1E11_111E_1111_1E00,
    64'h0E11_1010_1011_0E00, 64'h1C12_1111_1112_1C00,
    64'h1F10_101E_1010_1F00, 64'h1F10_101E_1010_1000
  };

  // ROM word for {digit, line}: 6 pixels, bit 5 = leftmost, bit 0 = spacing column.
  function automatic logic [5:0] font_word(input logic [6:0] addr);
    return {FontTable[addr[6:3]][{~addr[2:0], 3'b000} +: 5], 1'b0};
  endfunction

endpackage

// File: rtl/hex_font_rom.sv
// Glyph ROM for hex digits 0-F, 16 glyphs x 8 lines of 6 pixels, registered read.
// Contents come from the built-in glyph set in hex_monitor_pkg (address {digit, line},
// bit 5 = leftmost pixel); c_font_file is kept for interface compatibility and is unused.
// Ports: clk_i clock; addr_i {digit, line}; data_o pixel row, valid one cycle later.
module hex_font_rom #(
  parameter string c_font_file = "hex_font.mem"
) (
  input  logic       clk_i,
  input  logic [6:0] addr_i,
  output logic [5:0] data_o
);
  import hex_monitor_pkg::*;

  always_ff @(posedge clk_i) begin
    data_o <= font_word(addr_i);
  end

endmodule

// File: rtl/hex_monitor.sv
// Hex monitor: captures c_channels data words into shadow registers and renders them
// as a paged grid of hex digits on a pixel display. Changed nibbles are drawn red for
// c_highlight_frames frames after the capture that changed them.
// Ports: clk clock; reset synchronous active-high; ch_data packed channel words;
// ch_valid per-channel capture strobe; freeze blocks capture; page_next page request
// pulse; x/y pixel request; color pixel colour (2-cycle latency); page current page.
module hex_monitor #(
  parameter int unsigned c_channels         = 8,
  parameter int unsigned c_data_bits        = 64,
  parameter int unsigned c_x_size           = 96,
  parameter int unsigned c_y_size           = 64,
  parameter int unsigned c_color_bits       = 16,
  parameter string       c_font_file        = "hex_font.mem",
  parameter int unsigned c_highlight_frames = 30
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [c_channels*c_data_bits-1:0] ch_data,
  input  logic [c_channels-1:0]             ch_valid,
  input  logic                              freeze,
  input  logic                              page_next,
  input  logic [6:0]                        x,
  input  logic [5:0]                        y,
  output logic [c_color_bits-1:0]           color,
  output logic [7:0]                        page
);
  import hex_monitor_pkg::*;

  localparam int unsigned RowsVis = c_y_size / CellH;
  localparam int unsigned Cols    = c_data_bits / 4;
  localparam int unsigned Pages   = (c_channels + RowsVis - 1) / RowsVis;
  localparam int unsigned HlW     = $clog2(c_highlight_frames + 1);
  localparam int unsigned ChW     = (c_channels > 1) ? $clog2(c_channels) : 1;
  localparam int unsigned NibW    = (Cols > 1) ? $clog2(Cols) : 1;

  localparam logic [HlW-1:0] HlLoad = HlW'(c_highlight_frames);
  localparam logic [c_color_bits-1:0] ColLit =
      c_color_bits'((c_color_bits == 16) ? ColWhite16 : {8'h00, ColWhite8});
  localparam logic [c_color_bits-1:0] ColHl =
      c_color_bits'((c_color_bits == 16) ? ColRed16 : {8'h00, ColRed8});

  // ---------------------------------------------------------------------------
  // Frame tick: first cycle of a (0,0) request. Reset makes the "previous"
  // request look like non-origin so a (0,0) right after reset still ticks.
  // ---------------------------------------------------------------------------
  logic at_origin, frame_tick, prev_origin_q;
  assign at_origin  = (x == '0) && (y == '0);
  assign frame_tick = at_origin && !prev_origin_q;

  // ---------------------------------------------------------------------------
  // Channel capture, change mask and highlight timers
  // ---------------------------------------------------------------------------
  logic [c_data_bits-1:0] shadow_q [c_channels];
  logic [c_data_bits-1:0] shadow_d [c_channels];
  logic [Cols-1:0]        mask_q   [c_channels];
  logic [Cols-1:0]        mask_d   [c_channels];
  logic [HlW-1:0]         hl_q     [c_channels];
  logic [HlW-1:0]         hl_d     [c_channels];
  logic [Cols-1:0]        diff     [c_channels];

  always_comb begin
    for (int i = 0; i < c_channels; i++) begin
      for (int n = 0; n < Cols; n++) begin
        diff[i][n] = ch_data[i*c_data_bits + n*4 +: 4] != shadow_q[i][n*4 +: 4];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < c_channels; i++) begin
      shadow_d[i] = shadow_q[i];
      mask_d[i]   = mask_q[i];
      hl_d[i]     = hl_q[i];
      if (frame_tick && (hl_q[i] != '0)) begin
        hl_d[i] = hl_q[i] - 1'b1;
        if (hl_q[i] == HlW'(1)) mask_d[i] = '0;
      end
      // A changing capture overrides the decay applied above.
      if (ch_valid[i] && !freeze) begin
        shadow_d[i] = ch_data[i*c_data_bits +: c_data_bits];
        if (diff[i] != '0) begin
          hl_d[i]   = HlLoad;
          mask_d[i] = mask_q[i] | diff[i];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Page FSM: requests are latched and applied on the next frame tick
  // ---------------------------------------------------------------------------
  pg_state_t  pg_state_q, pg_state_d;
  logic [7:0] page_q, page_d;

  always_comb begin
    pg_state_d = pg_state_q;
    page_d     = page_q;
    case (pg_state_q)
      PG_IDLE: begin
        if (page_next) pg_state_d = PG_PENDING;
      end
      PG_PENDING: begin
        if (frame_tick) begin
          pg_state_d = PG_IDLE;
          page_d     = (page_q >= 8'(Pages - 1)) ? 8'd0 : page_q + 8'd1;
        end
      end
      default: pg_state_d = PG_IDLE;
    endcase
  end

  assign page = page_q;

  // ---------------------------------------------------------------------------
  // Pixel pipeline stage 1: cell decode and nibble select
  // ---------------------------------------------------------------------------
  logic [4:0]      cell_col;
  logic [2:0]      glyph_col, cell_row, glyph_line;
  logic [15:0]     ch_idx;
  logic            in_range;
  logic [ChW-1:0]  ch_sel;
  logic [NibW-1:0] nib_sel;
  logic [3:0]      digit;
  logic            hl_bit;

  assign cell_col   = 5'(x / 7'(CellW));
  assign glyph_col  = 3'(x % 7'(CellW));
  assign cell_row   = 3'(y / 6'(CellH));
  assign glyph_line = 3'(y % 6'(CellH));
  assign ch_idx     = 16'(page_q) * 16'(RowsVis) + 16'(cell_row);
  assign in_range   = (32'(ch_idx) < c_channels) && (32'(cell_col) < Cols) &&
                      (32'(x) < c_x_size) && (32'(cell_row) < RowsVis);
  // Column 0 carries the most significant nibble.
  assign ch_sel     = in_range ? ChW'(ch_idx) : '0;
  assign nib_sel    = in_range ? NibW'(Cols - 1 - 32'(cell_col)) : '0;
  assign digit      = shadow_q[ch_sel][{nib_sel, 2'b00} +: 4];
  assign hl_bit     = mask_q[ch_sel][nib_sel];

  logic       s1_valid_q, s1_hl_q;
  logic [3:0] s1_digit_q;
  logic [2:0] s1_line_q, s1_gcol_q;

  // Stage 2: font ROM read alongside the delayed cell attributes
  logic       s2_valid_q, s2_hl_q;
  logic [2:0] s2_gcol_q;
  logic [5:0] rom_data;

  hex_font_rom #(
    .c_font_file (c_font_file)
  ) u_font_rom (
    .clk_i  (clk),
    .addr_i ({s1_digit_q, s1_line_q}),
    .data_o (rom_data)
  );

  always_comb begin
    color = '0;
    if (s2_valid_q && (s2_gcol_q != 3'd5) && rom_data[3'd5 - s2_gcol_q]) begin
      color = s2_hl_q ? ColHl : ColLit;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < c_channels; i++) begin
        shadow_q[i] <= '0;
        mask_q[i]   <= '0;
        hl_q[i]     <= '0;
      end
      prev_origin_q <= 1'b0;
      pg_state_q    <= PG_IDLE;
      page_q        <= 8'd0;
      s1_valid_q    <= 1'b0;
      s1_hl_q       <= 1'b0;
      s1_digit_q    <= 4'd0;
      s1_line_q     <= 3'd0;
      s1_gcol_q     <= 3'd0;
      s2_valid_q    <= 1'b0;
      s2_hl_q       <= 1'b0;
      s2_gcol_q     <= 3'd0;
    end else begin
      for (int i = 0; i < c_channels; i++) begin
        shadow_q[i] <= shadow_d[i];
        mask_q[i]   <= mask_d[i];
        hl_q[i]     <= hl_d[i];
      end
      prev_origin_q <= at_origin;
      pg_state_q    <= pg_state_d;
      page_q        <= page_d;
      s1_valid_q    <= in_range;
      s1_hl_q       <= hl_bit;
      s1_digit_q    <= digit;
      s1_line_q     <= glyph_line;
      s1_gcol_q     <= glyph_col;
      s2_valid_q    <= s1_valid_q;
      s2_hl_q       <= s1_hl_q;
      s2_gcol_q     <= s1_gcol_q;
    end
  end

endmodule

// File: tb/tb_hex_monitor.sv
// Bench for hex_monitor with 12 channels (two pages of eight rows). Every pixel request
// pushes its expected colour to a scoreboard; the entry is popped and compared when the
// DUT produces that pixel two cycles later.
module tb_hex_monitor;

  localparam int NCH = 12;

  logic           clk;
  logic           rst;
  logic [NCH*64-1:0] ch_data;
  logic [NCH-1:0] ch_valid;
  logic           freeze;
  logic           page_next;
  logic [6:0]     x;
  logic [5:0]     y;
  logic [15:0]    color;
  logic [7:0]     page;

  hex_monitor #(
    .c_channels  (NCH),
    .c_font_file ("")
  ) dut (
    .clk       (clk),
    .reset     (rst),
    .ch_data   (ch_data),
    .ch_valid  (ch_valid),
    .freeze    (freeze),
    .page_next (page_next),
    .x         (x),
    .y         (y),
    .color     (color),
    .page      (page)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] col;
    int          px;
    int          py;
  } entry_t;
  entry_t sb[$];

  logic [63:0] font [16] = '{
    64'h0E11_1315_1911_0E00, 64'h040C_0404_0404_0E00,
    64'h0E11_0102_0408_1F00, 64'h1F02_0402_0111_0E00,
    64'h0206_0A12_1F02_0200, 64'h1F10_1E01_0111_0E00,
    64'h0608_101E_1111_0E00, 64'h1F01_0204_0808_0800,
    64'h0E11_110E_1111_0E00, 64'h0E11_110F_0102_0C00,
    64'h0E11_111F_1111_1100, 64'h1E11_111E_1111_1E00,
    64'h0E11_1010_1011_0E00, 64'h1C12_1111_1112_1C00,
    64'h1F10_101E_1010_1F00, 64'h1F10_101E_1010_1000
  };

  // Reference model state
  logic [63:0] m_shadow [NCH];
  logic [15:0] m_mask   [NCH];
  int          m_hl     [NCH];
  int          m_page;
  bit          m_pend;
  bit          m_prev0;

  function automatic logic [15:0] exp_color(input int cx, input int cy);
    int col, gc, row, line, ch, nib;
    logic [63:0] g;
    logic [4:0]  bits;
    col  = cx / 6;
    gc   = cx % 6;
    row  = cy / 8;
    line = cy % 8;
    ch   = m_page * 8 + row;
    if (ch >= NCH || col >= 16 || gc == 5) return 16'h0000;
    nib  = 15 - col;
    g    = font[m_shadow[ch][nib*4 +: 4]];
    bits = g[(7 - line) * 8 +: 5];
    if (!bits[4 - gc]) return 16'h0000;
    return m_mask[ch][nib] ? 16'hF800 : 16'hFFFF;
  endfunction

  task automatic model_update(input int cx, input int cy);
    bit          origin, tick;
    logic [15:0] diff, old_mask;
    logic [63:0] nw;
    origin = (cx == 0) && (cy == 0);
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_shadow[i] = '0;
        m_mask[i]   = '0;
        m_hl[i]     = 0;
      end
      m_page  = 0;
      m_pend  = 0;
      m_prev0 = 0;
      return;
    end
    tick = origin && !m_prev0;
    for (int i = 0; i < NCH; i++) begin
      old_mask = m_mask[i];
      if (tick && m_hl[i] > 0) begin
        m_hl[i]--;
        if (m_hl[i] == 0) m_mask[i] = '0;
      end
      if (ch_valid[i] && !freeze) begin
        nw = ch_data[i*64 +: 64];
        for (int n = 0; n < 16; n++) diff[n] = (nw[n*4 +: 4] != m_shadow[i][n*4 +: 4]);
        if (diff != '0) begin
          m_hl[i]   = 30;
          m_mask[i] = old_mask | diff;
        end
        m_shadow[i] = nw;
      end
    end
    if (!m_pend) begin
      if (page_next) m_pend = 1;
    end else if (tick) begin
      m_pend = 0;
      m_page = (m_page + 1) % 2;
    end
    m_prev0 = origin;
  endtask

  // One clock: check the pixel requested two cycles ago, present a new request.
  task automatic cycle(input int cx, input int cy);
    entry_t e;
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      checks++;
      assert (color === e.col) else begin
        errors++;
        $error("FAIL pix(%0d,%0d) observed %h expected %h", e.px, e.py, color, e.col);
      end
    end
    x = 7'(cx);
    y = 6'(cy);
    e.col = exp_color(cx, cy);
    e.px  = cx;
    e.py  = cy;
    sb.push_back(e);
    if (rst) begin
      // Reset flushes both pipeline stages: the next two outputs are blank.
      sb.delete();
      e.col = 16'h0000;
      e.px  = -1;
      e.py  = -1;
      sb.push_back(e);
      sb.push_back(e);
    end
    model_update(cx, cy);
    @(posedge clk);
    #1;
  endtask

  task automatic check_page(input string tag);
    checks++;
    assert (page === 8'(m_page)) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, page, m_page);
    end
  endtask

  task automatic capture(input int ch, input logic [63:0] val, input int cx, input int cy);
    ch_data[ch*64 +: 64] = val;
    ch_valid[ch] = 1'b1;
    cycle(cx, cy);
    ch_valid = '0;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      cycle(1, 1);
      cycle(0, 0);
    end
  endtask

  // Row-0 cells covering x0..x1, without touching (0,0).
  task automatic probe(input int x0, input int x1);
    for (int py = 0; py < 8; py++) begin
      for (int px = x0; px <= x1; px++) cycle(px, py);
    end
  endtask

  task automatic sweep_frame();
    for (int py = 0; py < 64; py++) begin
      for (int px = 0; px < 96; px++) cycle(px, py);
    end
  endtask

  initial begin
    rst       = 1'b1;
    ch_data   = '0;
    ch_valid  = '0;
    freeze    = 1'b0;
    page_next = 1'b0;
    x         = 7'd3;
    y         = 6'd3;
    @(posedge clk);
    #1;
    cycle(3, 3);
    cycle(3, 3);
    rst = 1'b0;
    check_page("page_reset");

    // Pixel values: fresh capture is red, white once the highlight has decayed.
    capture(0, 64'h0123_4567_89AB_CDEF, 2, 2);
    probe(1, 95);
    tick_n(30);
    sweep_frame();

    // Only the lowest nibble changes; red for exactly 30 frame ticks.
    capture(0, 64'h0123_4567_89AB_CDEE, 2, 2);
    probe(84, 95);
    tick_n(29);
    probe(84, 95);
    tick_n(1);
    probe(84, 95);

    // Freeze ignores captures but highlight decay continues.
    freeze = 1'b1;
    capture(0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 2);
    probe(1, 95);
    freeze = 1'b0;
    capture(0, 64'hFEDC_BA98_7654_3210, 2, 2);
    probe(1, 95);
    freeze = 1'b1;
    tick_n(30);
    probe(1, 95);
    freeze = 1'b0;

    // Paging: three requests in one frame advance a single page at the next tick.
    capture(8, 64'hA5A5_5A5A_0F0F_F0F0, 2, 2);
    capture(11, 64'h1357_9BDF_2468_ACE0, 2, 2);
    for (int k = 0; k < 3; k++) begin
      page_next = 1'b1;
      cycle(10 + k, 10);
      page_next = 1'b0;
      cycle(20 + k, 10);
    end
    check_page("page_pending");
    cycle(0, 0);
    check_page("page_advance");
    sweep_frame();
    page_next = 1'b1;
    cycle(1, 1);
    page_next = 1'b0;
    cycle(0, 0);
    check_page("page_wrap");

    // Reset mid-frame with a highlight active on page 1.
    page_next = 1'b1;
    cycle(1, 1);
    page_next = 1'b0;
    cycle(0, 0);
    check_page("page_one");
    capture(8, 64'h0000_1111_2222_3333, 2, 2);
    probe(1, 95);
    for (int px = 30; px < 40; px++) cycle(px, 20);
    rst = 1'b1;
    cycle(40, 20);
    rst = 1'b0;
    check_page("page_after_reset");
    probe(1, 95);

    // Capture coinciding with a frame tick reloads the full count.
    cycle(1, 1);
    ch_data[63:0] = 64'h0000_0000_0000_0001;
    ch_valid[0]   = 1'b1;
    cycle(0, 0);
    ch_valid = '0;
    tick_n(29);
    probe(84, 95);
    tick_n(1);
    probe(84, 95);

    cycle(1, 1);
    cycle(1, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
